// File: rtl/alu_sequencer.sv
// alu_sequencer: command-level controller for the 8-bit ALU.
// Each command is issued to the ALU as one or two write/read passes.
// 16-bit add/sub chains the low-pass carry/borrow into the high pass through alu_fi[0].
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// cmd_ready is high only in IDLE. rsp_valid stays high, with rsp_* stable, until rsp_ready is seen.
module alu_sequencer #(
    parameter int ALU_OP_W = 7,
    parameter int DATA_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [2*DATA_W-1:0]   cmd_a,
    input  logic [2*DATA_W-1:0]   cmd_b,
    input  logic                  cmd_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2*DATA_W-1:0]   rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [2:0]            dbg_state,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [DATA_W-1:0]     alu_fi,
    output logic [ALU_OP_W-1:0]   alu_op,
    output logic                  alu_wo,
    output logic                  alu_oe,
    input  logic [DATA_W-1:0]     alu_o,
    input  logic [DATA_W-1:0]     alu_fo
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE_LO = 3'd1,
        S_READ_LO  = 3'd2,
        S_ISSUE_HI = 3'd3,
        S_READ_HI  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD8  = 3'd0;
    localparam logic [2:0] OP_SUB8  = 3'd1;
    localparam logic [2:0] OP_AND8  = 3'd2;
    localparam logic [2:0] OP_OR8   = 3'd3;
    localparam logic [2:0] OP_NOT8  = 3'd4;
    localparam logic [2:0] OP_ADD16 = 3'd5;
    localparam logic [2:0] OP_SUB16 = 3'd6;
    localparam logic [2:0] OP_ILL   = 3'd7;

    state_t              state;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_hi;
    logic [DATA_W-1:0]   b_hi;
    logic [DATA_W-1:0]   res_lo;

    assign dbg_state = state;

    // Map a command op onto the ALU's one-hot op bus (same bus for both passes).
    function automatic logic [ALU_OP_W-1:0] op_onehot(input logic [2:0] op);
        logic [ALU_OP_W-1:0] oh;
        oh = '0;
        case (op)
            OP_ADD8, OP_ADD16: oh[0] = 1'b1;
            OP_SUB8, OP_SUB16: oh[1] = 1'b1;
            OP_AND8:           oh[2] = 1'b1;
            OP_OR8:            oh[3] = 1'b1;
            OP_NOT8:           oh[4] = 1'b1;
            default:           oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD8) || (op == OP_SUB8) || (op == OP_ADD16) || (op == OP_SUB16);
    endfunction

    function automatic logic is_wide(input logic [2:0] op);
        return (op == OP_ADD16) || (op == OP_SUB16);
    endfunction

    // Sequencer FSM: every output is registered and set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= '0;
            a_hi      <= '0;
            b_hi      <= '0;
            res_lo    <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_fi    <= '0;
            alu_op    <= '0;
            alu_wo    <= 1'b0;
            alu_oe    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        a_hi      <= cmd_a[2*DATA_W-1:DATA_W];
                        b_hi      <= cmd_b[2*DATA_W-1:DATA_W];
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op == OP_ILL) begin
                            // Illegal op never touches the ALU.
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_carry <= 1'b0;
                        end else begin
                            state  <= S_ISSUE_LO;
                            alu_a  <= cmd_a[DATA_W-1:0];
                            alu_b  <= cmd_b[DATA_W-1:0];
                            alu_op <= op_onehot(cmd_op);
                            alu_fi <= is_arith(cmd_op) ? DATA_W'(cmd_cin) : '0;
                            alu_wo <= 1'b1;
                        end
                    end
                end
                S_ISSUE_LO: begin
                    alu_wo <= 1'b0;
                    alu_oe <= 1'b1;
                    state  <= S_READ_LO;
                end
                S_READ_LO: begin
                    res_lo <= alu_o;
                    alu_oe <= 1'b0;
                    if (is_wide(op_q)) begin
                        // High pass: the low-pass carry/borrow enters through fi[0].
                        state  <= S_ISSUE_HI;
                        alu_a  <= a_hi;
                        alu_b  <= b_hi;
                        alu_fi <= DATA_W'(alu_fo[0]);
                        alu_wo <= 1'b1;
                    end else begin
                        state     <= S_DONE;
                        alu_a     <= '0;
                        alu_b     <= '0;
                        alu_fi    <= '0;
                        alu_op    <= '0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= (2*DATA_W)'(alu_o);
                        rsp_carry <= is_arith(op_q) & alu_fo[0];
                        rsp_err   <= 1'b0;
                    end
                end
                S_ISSUE_HI: begin
                    alu_wo <= 1'b0;
                    alu_oe <= 1'b1;
                    state  <= S_READ_HI;
                end
                S_READ_HI: begin
                    state     <= S_DONE;
                    alu_oe    <= 1'b0;
                    alu_a     <= '0;
                    alu_b     <= '0;
                    alu_fi    <= '0;
                    alu_op    <= '0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= {alu_o, res_lo};
                    rsp_carry <= alu_fo[0];
                    rsp_err   <= 1'b0;
                end
                S_DONE: begin
                    // Return to IDLE; a new command can only be taken on the following edge.
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    alu_wo    <= 1'b0;
                    alu_oe    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. It contains a registered ALU model and a spec-level
// transaction model that is checked on every cycle. Directed commands carry
// hand-computed literal expectations.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic        cmd_cin = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_err;
    logic        busy;
    logic [2:0]  dbg_state;
    logic [7:0]  alu_a, alu_b, alu_fi;
    logic [6:0]  alu_op;
    logic        alu_wo, alu_oe;
    logic [7:0]  alu_o, alu_fo;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.ALU_OP_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fi(alu_fi), .alu_op(alu_op),
        .alu_wo(alu_wo), .alu_oe(alu_oe), .alu_o(alu_o), .alu_fo(alu_fo)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU model: registered result/flags, loaded on wo, driven only while oe.
    // Logic ops leave a don't-care flag of 1 that the sequencer must not report.
    logic [7:0] alu_r;
    logic       alu_c;
    always @(posedge clk) begin
        if (rst) begin
            alu_r <= '0;
            alu_c <= 1'b0;
        end else if (alu_wo) begin
            case (alu_op)
                7'b0000001: {alu_c, alu_r} <= {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_fi[0]);
                7'b0000010: {alu_c, alu_r} <= {1'b0, alu_a} - {1'b0, alu_b} - 9'(alu_fi[0]);
                7'b0000100: begin alu_r <= alu_a & alu_b; alu_c <= 1'b1; end
                7'b0001000: begin alu_r <= alu_a | alu_b; alu_c <= 1'b1; end
                7'b0010000: begin alu_r <= ~alu_a;        alu_c <= 1'b1; end
                default:    begin alu_r <= 8'hEE;         alu_c <= 1'b1; end
            endcase
        end
    end
    assign alu_o  = alu_oe ? alu_r : 8'h00;
    assign alu_fo = alu_oe ? {7'b0, alu_c} : 8'h00;

    // Spec-level transaction model
    logic [6:0] onehot_tab [0:7] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h01, 7'h02, 7'h00};

    function automatic void model_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                      input logic cin, output logic [15:0] d, output logic c,
                                      output logic e, output logic clo, output int lat);
        logic [8:0]  s9;
        logic [16:0] s17;
        d = '0; c = 1'b0; e = 1'b0; clo = 1'b0; lat = 3;
        case (op)
            3'd0: begin s9 = a[7:0] + b[7:0] + cin; d = {8'h00, s9[7:0]}; c = s9[8]; end
            3'd1: begin s9 = {1'b0, a[7:0]} - {1'b0, b[7:0]} - cin; d = {8'h00, s9[7:0]}; c = s9[8]; end
            3'd2: d = {8'h00, a[7:0] & b[7:0]};
            3'd3: d = {8'h00, a[7:0] | b[7:0]};
            3'd4: d = {8'h00, ~a[7:0]};
            3'd5: begin
                s17 = a + b + cin; d = s17[15:0]; c = s17[16]; lat = 5;
                s9 = a[7:0] + b[7:0] + cin; clo = s9[8];
            end
            3'd6: begin
                s17 = {1'b0, a} - {1'b0, b} - cin; d = s17[15:0]; c = s17[16]; lat = 5;
                s9 = {1'b0, a[7:0]} - {1'b0, b[7:0]} - cin; clo = s9[8];
            end
            default: begin e = 1'b1; lat = 1; end
        endcase
    endfunction

    logic        m_on = 1'b0;
    logic        m_active = 1'b0;
    int          m_k = 0;
    int          m_lat = 0;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b, m_data;
    logic        m_cin, m_carry, m_err, m_clo;
    logic [15:0] t_d;
    logic        t_c, t_e, t_clo;
    int          t_lat;

    // Model update: accept whenever idle and cmd_valid, retire on rsp_ready.
    always @(posedge clk) begin
        if (rst) begin
            m_on     <= 1'b1;
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (cmd_valid) begin
                model_cmd(cmd_op, cmd_a, cmd_b, cmd_cin, t_d, t_c, t_e, t_clo, t_lat);
                m_active <= 1'b1;
                m_k      <= 1;
                m_op     <= cmd_op;
                m_a      <= cmd_a;
                m_b      <= cmd_b;
                m_cin    <= cmd_cin;
                m_data   <= t_d;
                m_carry  <= t_c;
                m_err    <= t_e;
                m_clo    <= t_clo;
                m_lat    <= t_lat;
            end
        end else if (m_k >= m_lat) begin
            if (rsp_ready) m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    logic [7:0] fi_log[$];
    int         oe_n = 0;

    // Compare process: checks every output against the model on each falling edge.
    always @(negedge clk) begin
        if (alu_wo) fi_log.push_back(alu_fi);
        if (alu_oe) oe_n++;
        if (m_on) begin
            if (!m_active) begin
                chk("idle_cmd_ready", cmd_ready, 1);
                chk("idle_busy", busy, 0);
                chk("idle_rsp_valid", rsp_valid, 0);
                chk("idle_alu", {alu_a, alu_b, alu_fi, alu_op, alu_wo, alu_oe}, 0);
            end else begin
                chk("act_cmd_ready", cmd_ready, 0);
                chk("act_busy", busy, 1);
                if (m_k >= m_lat) begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_data", rsp_data, m_data);
                    chk("rsp_carry", rsp_carry, m_carry);
                    chk("rsp_err", rsp_err, m_err);
                    chk("done_alu", {alu_a, alu_b, alu_fi, alu_op, alu_wo, alu_oe}, 0);
                end else begin
                    chk("pass_rsp_valid", rsp_valid, 0);
                    chk("pass_alu_a", alu_a, (m_k <= 2) ? m_a[7:0] : m_a[15:8]);
                    chk("pass_alu_b", alu_b, (m_k <= 2) ? m_b[7:0] : m_b[15:8]);
                    chk("pass_alu_op", alu_op, onehot_tab[m_op]);
                    chk("pass_alu_fi", alu_fi, (m_k <= 2) ? ((m_op == 2 || m_op == 3 || m_op == 4) ? 8'h00 : {7'b0, m_cin})
                                                          : {7'b0, m_clo});
                    chk("pass_alu_wo", alu_wo, (m_k == 1 || m_k == 3) ? 1 : 0);
                    chk("pass_alu_oe", alu_oe, (m_k == 2 || m_k == 4) ? 1 : 0);
                end
            end
        end
    end

    // Driver: issue one command at a negedge, wait for the response, hold rsp_ready low 'hold' cycles.
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input int hold, output int lat,
                           output logic [15:0] d, output logic c, output logic e);
        int w;
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        fi_log.delete();
        oe_n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_cin = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        d = rsp_data; c = rsp_carry; e = rsp_err;
        for (int h = 0; h < hold; h++) begin
            chk("hold_data", rsp_data, d);
            chk("hold_busy", busy, 1);
            chk("hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_idle", {cmd_ready, busy, rsp_valid}, 3'b100);
    endtask

    int          lat;
    logic [15:0] d;
    logic        c, e;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {cmd_ready, busy, rsp_valid, rsp_data, rsp_carry, rsp_err}, 21'h100000);
        chk("reset_alu", {alu_a, alu_b, alu_fi, alu_op, alu_wo, alu_oe}, 0);
        rst = 1'b0;
        @(negedge clk);

        // ADD8 0xF0+0x20
        run_cmd(3'd0, 16'h00F0, 16'h0020, 1'b0, 0, lat, d, c, e);
        chk("add8_lat", lat, 3);
        chk("add8_data", d, 16'h0010);
        chk("add8_carry", c, 1);
        chk("add8_wo_count", fi_log.size(), 1);
        chk("add8_oe_count", oe_n, 1);

        // ADD16 0x00FF+0x0001
        run_cmd(3'd5, 16'h00FF, 16'h0001, 1'b0, 0, lat, d, c, e);
        chk("add16_lat", lat, 5);
        chk("add16_data", d, 16'h0100);
        chk("add16_carry", c, 0);
        chk("add16_wo_count", fi_log.size(), 2);
        if (fi_log.size() == 2) begin
            chk("add16_fi_lo", fi_log[0], 8'h00);
            chk("add16_fi_hi", fi_log[1], 8'h01);
        end

        // SUB16 0x0100-0x0001
        run_cmd(3'd6, 16'h0100, 16'h0001, 1'b0, 0, lat, d, c, e);
        chk("sub16_data", d, 16'h00FF);
        chk("sub16_carry", c, 0);
        chk("sub16_err", e, 0);
        if (fi_log.size() == 2) chk("sub16_fi_hi", fi_log[1], 8'h01);
        else chk("sub16_wo_count", fi_log.size(), 2);

        // NOT8 0x5A with response held off 4 cycles
        run_cmd(3'd4, 16'h005A, 16'h00FF, 1'b1, 4, lat, d, c, e);
        chk("not8_data", d, 16'h00A5);
        chk("not8_carry", c, 0);

        // Illegal op
        run_cmd(3'd7, 16'h1234, 16'h5678, 1'b1, 0, lat, d, c, e);
        chk("ill_lat", lat, 1);
        chk("ill_err", e, 1);
        chk("ill_data", d, 16'h0000);
        chk("ill_carry", c, 0);
        chk("ill_wo_count", fi_log.size(), 0);
        chk("ill_oe_count", oe_n, 0);

        // More patterns
        run_cmd(3'd1, 16'h0010, 16'h0020, 1'b0, 1, lat, d, c, e);
        chk("sub8_data", d, 16'h00F0);
        chk("sub8_borrow", c, 1);
        run_cmd(3'd1, 16'h0005, 16'h0005, 1'b1, 0, lat, d, c, e);
        chk("sub8_bin_data", d, 16'h00FF);
        chk("sub8_bin_borrow", c, 1);
        run_cmd(3'd2, 16'hFFF0, 16'h003C, 1'b1, 0, lat, d, c, e);
        chk("and8_data", d, 16'h0030);
        chk("and8_carry", c, 0);
        run_cmd(3'd3, 16'h00A0, 16'h0005, 1'b0, 2, lat, d, c, e);
        chk("or8_data", d, 16'h00A5);
        run_cmd(3'd5, 16'hFFFF, 16'h0000, 1'b1, 0, lat, d, c, e);
        chk("add16_wrap_data", d, 16'h0000);
        chk("add16_wrap_carry", c, 1);
        run_cmd(3'd6, 16'h0000, 16'h0001, 1'b0, 0, lat, d, c, e);
        chk("sub16_under_data", d, 16'hFFFF);
        chk("sub16_under_borrow", c, 1);

        // Reset during READ_HI of ADD16
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_a = 16'h00FF; cmd_b = 16'h0001; cmd_cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_read_hi_oe", alu_oe, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_abort_alu", {alu_a, alu_b, alu_fi, alu_op, alu_wo, alu_oe}, 0);
        chk("rst_abort_ready", cmd_ready, 1);
        chk("rst_abort_rsp", rsp_valid, 0);
        repeat (3) @(negedge clk);
        chk("rst_abort_no_rsp", rsp_valid, 0);
        run_cmd(3'd0, 16'h0001, 16'h0002, 1'b0, 0, lat, d, c, e);
        chk("post_rst_add8_data", d, 16'h0003);
        chk("post_rst_add8_lat", lat, 3);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Command-level controller for the 8-bit ALU. It accepts one command at a time over a valid/ready handshake and drives the ALU's operand, one-hot op, flag-in, write-enable (wo) and output-enable (oe) pins. It captures the ALU's registered result and returns it over a valid/ready response channel. 16-bit add/sub runs as two chained 8-bit passes, with the low-pass carry/borrow fed into the high pass through fi[0].

Parameters:
ALU_OP_W, 7, width of the one-hot ALU op bus
DATA_W, 8, ALU datapath width; the wide command path is 2*DATA_W

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0 ADD8, 1 SUB8, 2 AND8, 3 OR8, 4 NOT8, 5 ADD16, 6 SUB16, 7 illegal
cmd_a  in  16  operand A (8-bit ops use [7:0])
cmd_b  in  16  operand B (8-bit ops use [7:0]; ignored by NOT8)
cmd_cin  in  1  carry/borrow-in for ADD/SUB first pass
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  consumer accepts
rsp_data  out  16  result; [15:8]=0 for 8-bit ops
rsp_carry  out  1  carry/borrow-out of final pass; 0 for AND/OR/NOT/illegal
rsp_err  out  1  1 for illegal op
busy  out  1  high in any state other than IDLE
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b
alu_fi  out  8  ALU flag-in; only bit 0 is ever nonzero
alu_op  out  7  one-hot: add 0000001, sub 0000010, and 0000100, or 0001000, not 0010000
alu_wo  out  1  ALU result/flag register load
alu_oe  out  1  ALU output enable
alu_o  in  8  ALU result
alu_fo  in  8  ALU flags; bit 0 is carry/borrow

Behaviour:
- Reset: state IDLE; every output 0 except cmd_ready=1. Operand and result registers are cleared. Reset in any state abandons the command: no rsp_valid and no further wo/oe pulse. Reset dominates all other inputs.
- States: IDLE, ISSUE_LO, READ_LO, ISSUE_HI, READ_HI, DONE.
- IDLE: on cmd_valid, latch cmd_op/a/b/cin. Legal op goes to ISSUE_LO; op 7 goes to DONE with rsp_err=1 and rsp_data=0. cmd_* is ignored outside IDLE.
- ISSUE_LO:
  - Drive alu_a=A[7:0], alu_b=B[7:0], alu_op per the op map, alu_wo=1.
  - alu_fi={7'b0,cin} for ADD/SUB, 0 otherwise.
  - Next state is READ_LO.
- READ_LO: alu_oe=1 and alu_a/b/op/fi held. On the clock edge, capture alu_o into res[7:0] and alu_fo[0] into carry. 16-bit ops go to ISSUE_HI; all others go to DONE.
- ISSUE_HI: alu_a=A[15:8], alu_b=B[15:8], alu_fi={7'b0,carry_lo}, same alu_op, alu_wo=1. Next state is READ_HI.
- READ_HI: alu_oe=1; capture res[15:8] and carry. Next state is DONE.
- Outside the ISSUE/READ states: alu_a/b/fi/op=0, alu_wo=0, alu_oe=0. alu_wo is never high for more than one consecutive cycle.
- DONE: rsp_valid=1, with rsp_* stable until the cycle rsp_ready=1. Then go to IDLE; no command is accepted in that same cycle.
- Latency, counted from the accept edge T to the first rsp_valid cycle: 8-bit ops T+3; 16-bit ops T+5; illegal op T+1.
- Minimum issue interval is one accept every latency+1 cycles.
- Carry semantics follow the ALU's 9-bit arithmetic. SUB carry=1 means a borrow occurred.

Test Plan:
- ADD8 a=0xF0 b=0x20 cin=0 -> alu_op=0000001 with wo at T+1, oe at T+2; rsp_valid at T+3, rsp_data=0x0010, rsp_carry=1.
- ADD16 a=0x00FF b=0x0001 cin=0 -> low pass alu_fi=0x00, high pass alu_fi=0x01; rsp at T+5, data=0x0100, carry=0.
- SUB16 a=0x0100 b=0x0001 cin=0 -> low pass borrow gives high-pass alu_fi=0x01; data=0x00FF, carry=0, rsp_err=0.
- NOT8 a=0x5A with rsp_ready held low 4 cycles -> rsp_data=0x00A5 stable for all 4 cycles, cmd_ready=0 and busy=1 throughout; IDLE the cycle after rsp_ready=1.
- Illegal cmd_op=7 -> rsp_valid at T+1 with rsp_err=1, data=0, carry=0; alu_wo and alu_oe never asserted.
- Assert rst during READ_HI of ADD16 -> next cycle all ALU outputs 0, cmd_ready=1, no rsp_valid; a following ADD8 0x01+0x02 returns 0x0003.
